// File: rtl/fwu_frame_rx_pkg.sv
// Shared definitions for the firmware-update frame receiver: marker default,
// status codes, parser state encoding and a constant-width helper.
package fwu_frame_rx_pkg;

  localparam logic [7:0] FWU_SOF_DEFAULT = 8'hA5;

  localparam logic [1:0] FWU_ERR_OK  = 2'b00;
  localparam logic [1:0] FWU_ERR_CHK = 2'b01;
  localparam logic [1:0] FWU_ERR_TMO = 2'b10;
  localparam logic [1:0] FWU_ERR_LEN = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CMD  = 3'd1,
    S_LEN  = 3'd2,
    S_PAY  = 3'd3,
    S_CHK  = 3'd4
  } fwu_state_e;

  // Smallest r with 2**r >= value.
  function automatic int fwu_clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/fwu_frame_rx_if.sv
// Byte-in / header + payload-out signal bundle of the frame receiver.
// Handshakes (in_*, pl_*): a transfer happens on a rising clk edge where valid
// and ready are both high; the sender holds data stable while valid && !ready.
interface fwu_frame_rx_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] cmd;
  logic [7:0] len;
  logic       hdr_valid;
  logic [7:0] pl_data;
  logic       pl_valid;
  logic       pl_ready;
  logic       pl_last;
  logic       done;
  logic [1:0] err;

  modport slave (
    input  in_data, in_valid, pl_ready,
    output in_ready, cmd, len, hdr_valid, pl_data, pl_valid, pl_last, done, err
  );

  modport master (
    output in_data, in_valid, pl_ready,
    input  in_ready, cmd, len, hdr_valid, pl_data, pl_valid, pl_last, done, err
  );
endinterface

// File: rtl/fwu_timeout_cnt.sv
// Reloadable, freezable cycle counter; o_expire pulses on the last counted
// cycle unless a reload arrives in that same cycle.
module fwu_timeout_cnt
  import fwu_frame_rx_pkg::*;
#(
  parameter int CYCLES = 50000,
  localparam int W     = fwu_clog2(CYCLES + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_run,
  input  logic i_freeze,
  input  logic i_reload,
  output logic o_expire
);

  localparam logic [W-1:0] LAST = W'(CYCLES - 1);

  logic [W-1:0] r_count;

  assign o_expire = i_run && !i_freeze && !i_reload && (r_count == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_reload || !i_run || o_expire) begin
      r_count <= '0;
    end else if (!i_freeze) begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/fwu_frame_rx.sv
// Frame parser behind the UART receiver: SOF, CMD, LEN, payload[LEN], CHK.
// Publishes the header, streams payload through a one-entry register, reports status.
module fwu_frame_rx
  import fwu_frame_rx_pkg::*;
#(
  parameter int         CLK_HZ     = 50000000,
  parameter int         TIMEOUT_US = 1000,
  parameter int         MAX_LEN    = 255,
  parameter logic [7:0] SOF_BYTE   = FWU_SOF_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  fwu_frame_rx_if.slave bus,
  output fwu_state_e    o_dbg_state
);

  localparam int TO_CYC = (CLK_HZ / 1000000) * TIMEOUT_US;

  fwu_state_e r_state;
  logic [7:0] r_sum;
  logic [7:0] r_rem;
  logic [7:0] r_cmd;
  logic [7:0] r_len;
  logic       r_hdr_valid;
  logic [7:0] r_pl_data;
  logic       r_pl_valid;
  logic       r_pl_last;
  logic       r_done;
  logic [1:0] r_err;

  logic       w_in_ready;
  logic       w_accept;
  logic       w_pl_take;
  logic       w_stall;
  logic       w_run;
  logic       w_expire;
  logic       w_len_bad;
  logic [7:0] w_sum_next;

  // A held payload byte blocks intake, which also delays the CHK byte and
  // therefore done until the final payload byte has been handed off.
  assign w_in_ready = !r_pl_valid || bus.pl_ready;
  assign w_accept   = bus.in_valid && w_in_ready;
  assign w_pl_take  = r_pl_valid && bus.pl_ready;
  assign w_stall    = r_pl_valid && !bus.pl_ready;
  assign w_run      = (r_state != S_IDLE);
  assign w_len_bad  = ({1'b0, bus.in_data} > 9'(MAX_LEN));
  assign w_sum_next = r_sum + bus.in_data;

  fwu_timeout_cnt #(
    .CYCLES (TO_CYC)
  ) u_timeout (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_run    (w_run),
    .i_freeze (w_stall),
    .i_reload (w_accept),
    .o_expire (w_expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_sum       <= '0;
      r_rem       <= '0;
      r_cmd       <= '0;
      r_len       <= '0;
      r_hdr_valid <= 1'b0;
      r_pl_data   <= '0;
      r_pl_valid  <= 1'b0;
      r_pl_last   <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= FWU_ERR_OK;
    end else begin
      r_hdr_valid <= 1'b0;
      r_done      <= 1'b0;
      if (w_pl_take) begin
        r_pl_valid <= 1'b0;
        r_pl_last  <= 1'b0;
      end

      if (w_expire) begin
        r_done     <= 1'b1;
        r_err      <= FWU_ERR_TMO;
        r_pl_valid <= 1'b0;
        r_pl_last  <= 1'b0;
        r_state    <= S_IDLE;
      end else if (w_accept) begin
        case (r_state)
          S_IDLE: begin
            if (bus.in_data == SOF_BYTE) begin
              r_sum   <= '0;
              r_state <= S_CMD;
            end
          end
          S_CMD: begin
            r_cmd   <= bus.in_data;
            r_sum   <= w_sum_next;
            r_state <= S_LEN;
          end
          S_LEN: begin
            r_len <= bus.in_data;
            r_sum <= w_sum_next;
            if (w_len_bad) begin
              r_done  <= 1'b1;
              r_err   <= FWU_ERR_LEN;
              r_state <= S_IDLE;
            end else begin
              r_hdr_valid <= 1'b1;
              r_rem       <= bus.in_data;
              r_state     <= (bus.in_data == 8'd0) ? S_CHK : S_PAY;
            end
          end
          S_PAY: begin
            r_pl_valid <= 1'b1;
            r_pl_data  <= bus.in_data;
            r_pl_last  <= (r_rem == 8'd1);
            r_sum      <= w_sum_next;
            r_rem      <= r_rem - 8'd1;
            if (r_rem == 8'd1) r_state <= S_CHK;
          end
          S_CHK: begin
            r_done  <= 1'b1;
            r_err   <= (bus.in_data == r_sum) ? FWU_ERR_OK : FWU_ERR_CHK;
            r_state <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.cmd       = r_cmd;
  assign bus.len       = r_len;
  assign bus.hdr_valid = r_hdr_valid;
  assign bus.pl_data   = r_pl_data;
  assign bus.pl_valid  = r_pl_valid;
  assign bus.pl_last   = r_pl_last;
  assign bus.done      = r_done;
  assign bus.err       = r_err;
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_fwu_frame_rx.sv
// Bench for fwu_frame_rx: frame table, hand-built timeout / back-pressure /
// reset sequences and randomised frames, all checked through expectation queues.
module tb_fwu_frame_rx;
  import fwu_frame_rx_pkg::*;

  localparam int CLK_HZ     = 1000000;
  localparam int TIMEOUT_US = 100;
  localparam int MAX_LEN    = 16;
  localparam int TO_CYC     = 100;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  fwu_state_e dbg_state;

  always #5 clk = ~clk;

  fwu_frame_rx_if bus ();

  fwu_frame_rx #(
    .CLK_HZ     (CLK_HZ),
    .TIMEOUT_US (TIMEOUT_US),
    .MAX_LEN    (MAX_LEN),
    .SOF_BYTE   (8'hA5)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  int   last_pl_cyc = -1;
  logic rnd_bp = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  logic [15:0] hdr_q[$];
  logic [8:0]  pl_q[$];
  logic [1:0]  done_q[$];
  logic [15:0] mon_h;
  logic [8:0]  mon_p;
  logic [1:0]  mon_d;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.hdr_valid || bus.done)
        check("hdr_done_apart", 32'(bus.hdr_valid && bus.done), 32'd0);
      if (bus.hdr_valid) begin
        check("hdr_expected", 32'(hdr_q.size() != 0), 32'd1);
        if (hdr_q.size() != 0) begin
          mon_h = hdr_q.pop_front();
          check("hdr_cmd_len", 32'({bus.cmd, bus.len}), 32'(mon_h));
        end
      end
      if (bus.pl_valid && bus.pl_ready) begin
        check("pl_expected", 32'(pl_q.size() != 0), 32'd1);
        if (pl_q.size() != 0) begin
          mon_p = pl_q.pop_front();
          check("pl_last_data", 32'({bus.pl_last, bus.pl_data}), 32'(mon_p));
        end
        if (bus.pl_last) last_pl_cyc = cyc;
      end
      if (bus.done) begin
        check("done_expected", 32'(done_q.size() != 0), 32'd1);
        if (done_q.size() != 0) begin
          mon_d = done_q.pop_front();
          check("done_err", 32'(bus.err), 32'(mon_d));
        end
        check("done_after_payload", 32'(pl_q.size() == 0 && last_pl_cyc != cyc), 32'd1);
      end
    end
  end

  // Random downstream back-pressure, active only when rnd_bp is set.
  always @(posedge clk) begin
    #1;
    if (rnd_bp) bus.pl_ready = 1'($urandom_range(0, 1));
  end

  // ---------------- driver tasks ----------------
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    @(negedge clk);
    while (!bus.in_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) check("byte_accept_wait", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((done_q.size() != 0 || hdr_q.size() != 0 || pl_q.size() != 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("drain_done_q", 32'(done_q.size()), 32'd0);
    check("drain_pl_q", 32'(pl_q.size() + hdr_q.size()), 32'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] model_sum(input logic [7:0] c, input logic [7:0] l,
                                           input logic [127:0] pl);
    logic [7:0] s;
    s = c + l;
    for (int i = 0; i < int'(l) && i < 16; i++) s = s + pl[i*8 +: 8];
    return s;
  endfunction

  task automatic run_frame(input logic [7:0] c, input logic [7:0] l, input logic [127:0] pl,
                           input logic [7:0] chk, input logic junk, input logic [1:0] exp_err);
    logic [8:0] e;
    if (junk) begin
      send_byte(8'h00);
      send_byte(8'hFF);
    end
    if (exp_err != FWU_ERR_LEN) begin
      hdr_q.push_back({c, l});
      for (int i = 0; i < int'(l); i++) begin
        e = {(i == int'(l) - 1), pl[i*8 +: 8]};
        pl_q.push_back(e);
      end
    end
    done_q.push_back(exp_err);
    send_byte(8'hA5);
    send_byte(c);
    send_byte(l);
    if (exp_err != FWU_ERR_LEN) begin
      for (int i = 0; i < int'(l); i++) send_byte(pl[i*8 +: 8]);
      send_byte(chk);
    end
    wait_drain();
  endtask

  task automatic check_reset_outputs();
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_hdr_valid", 32'(bus.hdr_valid), 32'd0);
    check("rst_pl_valid", 32'(bus.pl_valid), 32'd0);
    check("rst_pl_last_data", 32'({bus.pl_last, bus.pl_data}), 32'd0);
    check("rst_done_err", 32'({bus.done, bus.err}), 32'd0);
    check("rst_cmd_len", 32'({bus.cmd, bus.len}), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(S_IDLE));
  endtask

  // ---------------- stimulus table ----------------
  typedef struct packed {
    logic [7:0]   cmd;
    logic [7:0]   len;
    logic [127:0] pl;
    logic [7:0]   chk;
    logic         junk;
    logic [1:0]   exp_err;
  } vec_t;

  localparam int NVEC = 7;
  vec_t vecs[NVEC];

  initial begin
    int n;
    logic [7:0]   rc, rl, rs;
    logic [127:0] rp;
    logic         bad;
    logic [1:0]   re;

    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    bus.pl_ready = 1'b1;

    vecs[0] = '{8'h01, 8'h02, 128'h2010, 8'h33, 1'b0, FWU_ERR_OK};
    vecs[1] = '{8'h01, 8'h02, 128'h2010, 8'h34, 1'b0, FWU_ERR_CHK};
    vecs[2] = '{8'h07, 8'h00, 128'h0, 8'h07, 1'b1, FWU_ERR_OK};
    vecs[3] = '{8'h02, 8'h11, 128'h0, 8'h00, 1'b0, FWU_ERR_LEN};
    vecs[4] = '{8'h3C, 8'h04, 128'h01FF00A5, 8'hE5, 1'b0, FWU_ERR_OK};
    vecs[5] = '{8'h10, 8'h10, 128'h0F0E0D0C0B0A09080706050403020100, 8'h98, 1'b0, FWU_ERR_OK};
    vecs[6] = '{8'hFF, 8'h01, 128'h80, 8'h80, 1'b0, FWU_ERR_OK};

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs();
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < NVEC; i++)
      run_frame(vecs[i].cmd, vecs[i].len, vecs[i].pl, vecs[i].chk, vecs[i].junk, vecs[i].exp_err);

    // Stalled link: done/timeout exactly TO_CYC cycles after the last accepted byte.
    hdr_q.push_back({8'h01, 8'h03});
    pl_q.push_back({1'b0, 8'hAA});
    done_q.push_back(FWU_ERR_TMO);
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h03);
    send_byte(8'hAA);
    n = 0;
    while (n < 300) begin
      @(posedge clk);
      n++;
      #1;
      if (bus.done) break;
    end
    check("timeout_latency", 32'(n), 32'(TO_CYC));
    check("timeout_state", 32'(dbg_state), 32'(S_IDLE));
    check("timeout_pl_cleared", 32'({bus.pl_valid, bus.pl_last}), 32'd0);
    wait_drain();
    run_frame(vecs[0].cmd, vecs[0].len, vecs[0].pl, vecs[0].chk, 1'b0, FWU_ERR_OK);

    // Byte arriving in the expiry cycle must win over the timeout.
    hdr_q.push_back({8'h01, 8'h01});
    pl_q.push_back({1'b1, 8'h42});
    done_q.push_back(FWU_ERR_OK);
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h01);
    repeat (TO_CYC - 1) @(posedge clk);
    #1;
    send_byte(8'h42);
    send_byte(8'h44);
    wait_drain();

    // Long downstream stall mid-payload: no timeout, no loss.
    hdr_q.push_back({8'h05, 8'h04});
    pl_q.push_back({1'b0, 8'h11});
    pl_q.push_back({1'b0, 8'h22});
    pl_q.push_back({1'b0, 8'h33});
    pl_q.push_back({1'b1, 8'h44});
    done_q.push_back(FWU_ERR_OK);
    bus.pl_ready = 1'b0;
    fork
      begin
        send_byte(8'hA5);
        send_byte(8'h05);
        send_byte(8'h04);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h44);
        send_byte(8'hB3);
      end
      begin
        repeat (500) @(posedge clk);
        #1;
        check("stall_in_ready", 32'(bus.in_ready), 32'd0);
        check("stall_state", 32'(dbg_state), 32'(S_PAY));
        check("stall_done_pending", 32'(done_q.size()), 32'd1);
        bus.pl_ready = 1'b1;
      end
    join
    wait_drain();

    // Asynchronous reset while a payload byte is held.
    hdr_q.push_back({8'h09, 8'h03});
    bus.pl_ready = 1'b0;
    send_byte(8'hA5);
    send_byte(8'h09);
    send_byte(8'h03);
    send_byte(8'h01);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    check("rst_hdr_seen", 32'(hdr_q.size()), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.pl_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_no_done", 32'({bus.done, bus.pl_valid}), 32'd0);
    run_frame(vecs[4].cmd, vecs[4].len, vecs[4].pl, vecs[4].chk, 1'b0, FWU_ERR_OK);

    // Random frames under random back-pressure, checked against a sum model.
    rnd_bp = 1'b1;
    for (int k = 0; k < 12; k++) begin
      rc  = 8'($urandom_range(0, 255));
      rl  = 8'($urandom_range(0, MAX_LEN + 2));
      rp  = {$urandom, $urandom, $urandom, $urandom};
      bad = ($urandom_range(0, 3) == 0);
      rs  = model_sum(rc, rl, rp);
      re  = (int'(rl) > MAX_LEN) ? FWU_ERR_LEN : (bad ? FWU_ERR_CHK : FWU_ERR_OK);
      run_frame(rc, rl, rp, bad ? (rs ^ 8'h5A) : rs, 1'b0, re);
    end
    rnd_bp = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    bus.pl_ready = 1'b1;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", n_errors, n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/fwu_frame_rx.md
Name: fwu_frame_rx

Overview:
- Byte-stream frame parser directly downstream of the UART receiver in the firmware-update path.
- Consumes received bytes over a valid/ready handshake and delineates frames of the form SOF, CMD, LEN, payload[LEN], CHK.
- Emits the command header, streams the payload bytes out, then reports frame completion with an ok/error code.
- Feeds the firmware-update command executor and SPI-flash writer.

Parameters:
- CLK_HZ, 50000000, system clock frequency in Hz.
- TIMEOUT_US, 1000, maximum inter-byte gap in microseconds inside a frame before the frame is aborted.
- MAX_LEN, 255, largest legal LEN value; must be in the range 1..255.
- SOF_BYTE, 8'hA5, start-of-frame marker.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset
- in_data  in  8  byte from the UART receiver
- in_valid  in  1  in_data valid
- in_ready  out  1  byte accepted when in_valid && in_ready
- cmd  out  8  command byte of the current frame
- len  out  8  payload length of the current frame
- hdr_valid  out  1  one-cycle pulse when cmd and len are captured
- pl_data  out  8  payload byte
- pl_valid  out  1  payload byte valid
- pl_ready  in  1  downstream accepts payload byte
- pl_last  out  1  qualifies the final payload byte
- done  out  1  one-cycle pulse at frame end or abort
- err  out  2  status, valid with done: 00 ok, 01 checksum, 10 timeout, 11 length

Behaviour:
- Reset: rst_n is asynchronous, active-low; clock is clk. All outputs reset to 0, except in_ready, which resets to 1. State resets to S_IDLE and the timeout counter to 0.
- Derived constants:
  - TO_CYC = (CLK_HZ/1000000)*TIMEOUT_US.
  - Counter width = clog2(TO_CYC+1).
- Checksum:
  - Running 8-bit sum, mod 256, of CMD, LEN and all payload bytes.
  - The frame is ok when the CHK byte equals the running sum.
- States. Each transition happens on an accepted input byte.
  - S_IDLE:
    - A byte equal to SOF_BYTE moves to S_CMD and clears the sum.
    - Any other byte is silently dropped.
    - in_ready is 1.
  - S_CMD: captures cmd, adds it to the sum, moves to S_LEN.
  - S_LEN: captures len and adds it to the sum, then:
    - If LEN > MAX_LEN: pulse done with err=11 and return to S_IDLE. Do not pulse hdr_valid.
    - Otherwise: pulse hdr_valid next cycle.
    - If LEN == 0, go to S_CHK; else go to S_PAY with the remaining count = LEN.
  - S_PAY:
    - Each accepted byte loads the single-entry output register: pl_valid=1, pl_data=byte, pl_last=(remaining==1).
    - The byte is added to the sum and the remaining count is decremented.
    - The state moves to S_CHK after the LEN-th byte.
    - in_ready = !pl_valid || pl_ready. No byte is lost under back-pressure.
    - pl_valid clears on pl_valid && pl_ready unless a new byte is loaded the same cycle.
  - S_CHK:
    - The CHK byte is compared with the sum.
    - done pulses with err=00 on match, else err=01.
    - Returns to S_IDLE.
    - If the last payload byte is still unaccepted downstream, done is delayed until the cycle after that byte's handshake, so done never precedes pl_last acceptance.
- Timeout:
  - The counter runs only in S_CMD, S_LEN, S_PAY and S_CHK.
  - It reloads to 0 on every accepted byte.
  - It is frozen while pl_valid && !pl_ready, so downstream stalls are not blamed on the link.
  - When it reaches TO_CYC-1: pulse done with err=10, clear pl_valid/pl_last, return to S_IDLE.
  - If a byte is accepted in the same cycle as expiry, the byte wins: no timeout, counter reloads.
- cmd and len hold their values until the next frame's capture.
- done and hdr_valid are never asserted in the same cycle.
- The consumer discards or rolls back the payload of any frame that ends with err≠00.
- Reset mid-frame: immediate return to S_IDLE with all outputs at reset values; no done pulse.
- A SOF_BYTE value appearing inside a frame is treated as ordinary data; there is no resynchronisation until frame end or timeout.

Decomposition:
- Shared package / fwu_defs.vh holds:
  - SOF_BYTE default.
  - err code constants FWU_ERR_OK/CHK/TMO/LEN.
  - State encodings S_IDLE/S_CMD/S_LEN/S_PAY/S_CHK.
  - The clog2 function.
- One natural sub-module, fwu_timeout_cnt: a reloadable, freezable counter with an expiry pulse, parameterised by cycle count. It is reusable for the TX-side response timer.

Test Plan:
- Feed A5 01 02 10 20 33, pl_ready=1 → hdr_valid with cmd=01 len=02; pl_data 10 then 20 (pl_last on 20); done with err=00.
- Same frame with CHK=34 → payload 10, 20 still streamed; done with err=01.
- Feed 00 FF A5 07 00 07 → leading 00 and FF dropped; hdr_valid with cmd=07 len=00; no pl_valid; done err=00.
- Feed A5 01 03 AA, then stall with TO_CYC=100 (set via CLK_HZ/TIMEOUT_US) → done with err=10 exactly 100 cycles after AA is accepted; state back to idle; next A5 frame parses cleanly.
- Hold pl_ready=0 for 500 cycles during a 4-byte payload → in_ready low, no timeout, no byte lost; done follows pl_last acceptance.
- MAX_LEN=16, feed A5 02 11 → done with err=11 and no hdr_valid. Separately, assert rst_n low mid-payload → outputs at reset values, no done.
